// File: rtl/kernel_load_ctrl.sv
// Sequences the kernel register file: loads N weights from a valid/ready
// stream, then replays them as taps to the MAC, one window per request.
module kernel_load_ctrl #(
    parameter int BIT_DEPTH   = 8,
    parameter int KERNEL_SIZE = 3,
    parameter int ADDR_W      = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load_start,
    input  logic                 abort,
    input  logic                 s_valid,
    input  logic [BIT_DEPTH-1:0] s_data,
    output logic                 s_ready,
    output logic                 kr_wr_en,
    output logic [ADDR_W-1:0]    kr_addr,
    output logic [BIT_DEPTH-1:0] kr_wdata,
    input  logic [BIT_DEPTH-1:0] kr_rdata,
    input  logic                 win_start,
    output logic                 tap_valid,
    output logic [BIT_DEPTH-1:0] tap_data,
    output logic [ADDR_W-1:0]    tap_idx,
    output logic                 tap_last,
    input  logic                 tap_ready,
    output logic                 loaded,
    output logic                 busy,
    output logic                 win_done
);

    localparam int N = KERNEL_SIZE * KERNEL_SIZE;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        ARMED,
        SCAN
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic                loaded_q, loaded_d;
    logic                win_done_q, win_done_d;
    logic                in_load, in_scan, at_last;

    assign in_load = (state_q == LOAD);
    assign in_scan = (state_q == SCAN);
    assign at_last = (cnt_q == LAST);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        loaded_d   = loaded_q;
        win_done_d = 1'b0;
        if (abort) begin
            state_d  = IDLE;
            cnt_d    = '0;
            loaded_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (load_start) begin
                        state_d = LOAD;
                        cnt_d   = '0;
                    end
                end
                LOAD: begin
                    if (s_valid) begin
                        if (at_last) begin
                            state_d  = ARMED;
                            cnt_d    = '0;
                            loaded_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                ARMED: begin
                    // a reload drops loaded at once so a partial kernel is never used
                    if (load_start) begin
                        state_d  = LOAD;
                        cnt_d    = '0;
                        loaded_d = 1'b0;
                    end else if (win_start) begin
                        state_d = SCAN;
                        cnt_d   = '0;
                    end
                end
                SCAN: begin
                    if (tap_ready) begin
                        if (at_last) begin
                            state_d    = ARMED;
                            cnt_d      = '0;
                            win_done_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            loaded_q   <= 1'b0;
            win_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            loaded_q   <= loaded_d;
            win_done_q <= win_done_d;
        end
    end

    assign s_ready   = in_load;
    assign kr_wr_en  = in_load & s_valid;
    assign kr_wdata  = in_load ? s_data : '0;
    assign kr_addr   = (in_load | in_scan) ? cnt_q : '0;
    assign tap_valid = in_scan;
    assign tap_idx   = in_scan ? cnt_q : '0;
    assign tap_data  = in_scan ? kr_rdata : '0;
    assign tap_last  = in_scan & at_last;
    assign busy      = in_load | in_scan;
    assign loaded    = loaded_q;
    assign win_done  = win_done_q;

endmodule

// File: tb/tb_kernel_load_ctrl.sv
// Bench for kernel_load_ctrl: vector table plus write/tap scoreboards
// against a behavioural kernel register file.
module tb_kernel_load_ctrl;

    logic       clk, rst_n;
    logic       load_start, abort, s_valid, win_start, tap_ready;
    logic [7:0] s_data, kr_wdata, kr_rdata, tap_data;
    logic [3:0] kr_addr, tap_idx;
    logic       s_ready, kr_wr_en, tap_valid, tap_last;
    logic       loaded, busy, win_done;

    kernel_load_ctrl #(.BIT_DEPTH(8), .KERNEL_SIZE(3), .ADDR_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .load_start(load_start), .abort(abort),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .kr_wr_en(kr_wr_en), .kr_addr(kr_addr), .kr_wdata(kr_wdata),
        .kr_rdata(kr_rdata), .win_start(win_start), .tap_valid(tap_valid),
        .tap_data(tap_data), .tap_idx(tap_idx), .tap_last(tap_last),
        .tap_ready(tap_ready), .loaded(loaded), .busy(busy),
        .win_done(win_done)
    );

    logic [7:0] mem [16];
    always @(posedge clk) if (kr_wr_en) mem[kr_addr] <= kr_wdata;
    assign kr_rdata = mem[kr_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       ls, ws, ab, sv;
        logic [7:0] sd;
        logic       tr;
        logic [4:0] exp;
    } vec_t;

    typedef struct { logic [3:0] a; logic [7:0] d; } wr_t;
    typedef struct { logic [3:0] i; logic [7:0] d; logic l; } tap_t;

    vec_t tbl[$];
    wr_t  wq[$];
    tap_t tq[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   bcnt;
    wr_t  we;
    tap_t te;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        n_vec++;
        n_err++;
        $display("FAIL %s: got unexpected event expected none", nm);
    endtask

    task automatic push_wr(input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++) wq.push_back('{4'(i), base + 8'(i)});
    endtask

    task automatic push_tap(input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++)
            tq.push_back('{4'(i), base + 8'(i), (i == 8)});
    endtask

    // drive after the falling edge, observe 1ns later, pop scoreboards
    task automatic apply(input logic ls, ws, ab, sv, input logic [7:0] sd,
                         input logic tr);
        @(negedge clk);
        load_start = ls; win_start = ws; abort = ab;
        s_valid = sv; s_data = sd; tap_ready = tr;
        #1;
        if (kr_wr_en) begin
            if (wq.size() == 0) fail_now("wr_unexpected");
            else begin
                we = wq.pop_front();
                chk("wr_addr_data", {kr_addr, kr_wdata}, {we.a, we.d});
            end
        end
        if (tap_valid && tap_ready) begin
            if (tq.size() == 0) fail_now("tap_unexpected");
            else begin
                te = tq.pop_front();
                chk("tap_idx_data_last", {tap_idx, tap_data, tap_last},
                    {te.i, te.d, te.l});
            end
        end
    endtask

    function automatic void add(input logic ls, ws, ab, sv,
                                input logic [7:0] sd, input logic tr,
                                input logic [4:0] e);
        vec_t v;
        v.ls = ls; v.ws = ws; v.ab = ab; v.sv = sv;
        v.sd = sd; v.tr = tr; v.exp = e;
        tbl.push_back(v);
    endfunction

    function automatic logic [30:0] all_out();
        return {loaded, win_done, busy, s_ready, tap_valid, tap_last,
                kr_wr_en, kr_addr, tap_idx, kr_wdata, tap_data};
    endfunction

    initial begin
        // exp = {loaded, busy, s_ready, tap_valid, win_done}
        add(0, 0, 0, 0, 8'd0, 0, 5'b00000);
        add(1, 0, 0, 0, 8'd0, 0, 5'b00000);
        for (int i = 0; i < 9; i++) add(0, 0, 0, 1, 8'(i + 1), 0, 5'b01100);
        add(0, 0, 0, 0, 8'd0, 0, 5'b10000);
        add(0, 1, 0, 0, 8'd0, 1, 5'b10000);
        for (int i = 0; i < 9; i++) add(0, 0, 0, 0, 8'd0, 1, 5'b11010);
        add(0, 0, 0, 0, 8'd0, 1, 5'b10001);
        add(0, 0, 0, 0, 8'd0, 0, 5'b10000);

        rst_n = 1'b0; load_start = 0; win_start = 0; abort = 0;
        s_valid = 0; s_data = 0; tap_ready = 0;
        #3;
        chk("reset_outputs", 64'(all_out()), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // load 1..9 with s_valid high, then one full scan
        push_wr(9, 8'd1);
        push_tap(9, 8'd1);
        for (int k = 0; k < tbl.size(); k++) begin
            apply(tbl[k].ls, tbl[k].ws, tbl[k].ab, tbl[k].sv,
                  tbl[k].sd, tbl[k].tr);
            chk($sformatf("vec%0d", k),
                {loaded, busy, s_ready, tap_valid, win_done}, tbl[k].exp);
        end

        // scan with a 3-cycle stall at idx 4
        push_tap(9, 8'd1);
        apply(0, 1, 0, 0, 8'd0, 1);
        for (int k = 0; k < 4; k++) apply(0, 0, 0, 0, 8'd0, 1);
        for (int k = 0; k < 3; k++) begin
            apply(0, 0, 0, 0, 8'd0, 0);
            chk("stall_hold", {tap_valid, tap_idx, tap_data, kr_addr},
                {1'b1, 4'd4, 8'd5, 4'd4});
        end
        for (int k = 0; k < 5; k++) apply(0, 0, 0, 0, 8'd0, 1);
        apply(0, 0, 0, 0, 8'd0, 1);
        chk("stall_win_done", {win_done, busy}, 2'b10);
        apply(0, 0, 0, 0, 8'd0, 0);
        chk("win_done_pulse", win_done, 1'b0);

        // toggling s_valid load of 0x11..0x19
        push_wr(9, 8'h11);
        apply(1, 0, 0, 0, 8'd0, 0);
        bcnt = 0;
        for (int k = 0; k < 40; k++) begin
            apply(0, 0, 0, (k % 2 == 0), 8'h11 + 8'(k / 2), 0);
            if (!busy) break;
            bcnt++;
        end
        chk("toggle_load_cycles", bcnt, 17);
        chk("toggle_loaded", loaded, 1'b1);

        // load_start and win_start together in ARMED
        apply(1, 1, 0, 0, 8'd0, 1);
        apply(0, 0, 0, 0, 8'd0, 1);
        chk("ls_ws_collide", {loaded, busy, s_ready, tap_valid},
            4'b0110);
        push_wr(9, 8'd1);
        for (int i = 0; i < 9; i++) apply(0, 0, 0, 1, 8'(i + 1), 0);
        apply(0, 0, 0, 0, 8'd0, 0);
        chk("reload_done", {loaded, busy}, 2'b10);

        // abort at load idx 5, then a win_start that must be ignored
        push_wr(5, 8'hA0);
        apply(1, 0, 0, 0, 8'd0, 0);
        for (int i = 0; i < 5; i++) apply(0, 0, 0, 1, 8'hA0 + 8'(i), 0);
        apply(0, 0, 1, 0, 8'd0, 0);
        chk("abort_cycle", {busy, kr_addr}, {1'b1, 4'd5});
        apply(0, 1, 0, 0, 8'd0, 1);
        chk("after_abort", {loaded, busy, win_done}, 3'b000);
        apply(0, 0, 0, 0, 8'd0, 1);
        chk("ws_ignored", {loaded, busy, tap_valid}, 3'b000);

        // reload, then async reset mid-scan at idx 3
        push_wr(9, 8'd1);
        apply(1, 0, 0, 0, 8'd0, 0);
        for (int i = 0; i < 9; i++) apply(0, 0, 0, 1, 8'(i + 1), 0);
        push_tap(3, 8'd1);
        apply(0, 1, 0, 0, 8'd0, 1);
        for (int k = 0; k < 3; k++) apply(0, 0, 0, 0, 8'd0, 1);
        apply(0, 0, 0, 0, 8'd0, 0);
        chk("scan_idx3", {tap_valid, tap_idx, tap_data}, {1'b1, 4'd3, 8'd4});
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", 64'(all_out()), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        apply(0, 1, 0, 0, 8'd0, 1);
        chk("post_reset_idle", {loaded, busy}, 2'b00);
        apply(0, 0, 0, 0, 8'd0, 1);
        chk("post_reset_ws_ignored", {loaded, busy, tap_valid}, 3'b000);

        chk("wr_queue_empty", wq.size(), 0);
        chk("tap_queue_empty", tq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
